// File: rtl/div_core_radix2_if.sv
// Request/response bundle for the radix-2 divider: operands and request strobe in,
// registered quotient/remainder and ready out.
interface div_core_radix2_if #(
    parameter int WIDTH = 32
);
    // Handshake: the master drives enable together with op1/op2/sign_en. The slave
    // accepts on a rising clk edge only while ready=1. enable while ready=0 is dropped.
    // Once ready is 1 again, quo_o/rem_o hold the result of the last accepted request.
    logic             enable;
    logic             sign_en;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] quo_o;
    logic [WIDTH-1:0] rem_o;
    logic             ready;

    modport master (
        output enable, sign_en, op1, op2,
        input  quo_o, rem_o, ready
    );

    modport slave (
        input  enable, sign_en, op1, op2,
        output quo_o, rem_o, ready
    );
endinterface

// File: rtl/div_core_radix2.sv
// Multi-cycle radix-2 non-restoring divider, signed or unsigned, one quotient bit per cycle.
// Define DIV_FAST_EN to let PREP jump straight to FIX when |op1|<|op2| or op2=0.
module div_core_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    div_core_radix2_if.slave        io_bus,
    output logic [1:0]              o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_CALC = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_op2;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH+1:0] r_p;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [5:0]       r_cnt;
    logic             r_sign;
    logic             r_qsign;
    logic             r_rsign;

    logic             w_ready;
    logic             w_div0;
    logic             w_skip;
    logic             w_calc_done;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic [WIDTH-1:0] w_rem_mag;
    logic [WIDTH+1:0] w_b_ext;
    logic [WIDTH+1:0] w_p_shift;
    logic [WIDTH+1:0] w_p_step;
    logic [WIDTH+1:0] w_p_fix;

    assign w_abs1 = (r_sign && r_op1[WIDTH-1]) ? -r_op1 : r_op1;
    assign w_abs2 = (r_sign && r_op2[WIDTH-1]) ? -r_op2 : r_op2;
    assign w_div0 = (r_op2 == '0);

    // Partial remainder stays in [-B, B); two extra bits cover the doubled value and sign.
    assign w_b_ext     = {2'b00, r_b};
    assign w_p_shift   = {r_p[WIDTH:0], r_a[WIDTH-1]};
    assign w_p_step    = r_p[WIDTH+1] ? (w_p_shift + w_b_ext) : (w_p_shift - w_b_ext);
    assign w_p_fix     = r_p[WIDTH+1] ? (r_p + w_b_ext) : r_p;
    assign w_rem_mag   = w_p_fix[WIDTH-1:0];
    assign w_calc_done = (r_cnt == 6'(WIDTH - 1));

`ifdef DIV_FAST_EN
    assign w_skip = (w_abs1 < w_abs2) || w_div0;
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (io_bus.enable) w_state_nxt = S_PREP;
            end
            S_PREP:  w_state_nxt = w_skip ? S_FIX : S_CALC;
            S_CALC:  if (w_calc_done) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op1   <= '0;
            r_op2   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_p     <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_sign  <= 1'b0;
            r_qsign <= 1'b0;
            r_rsign <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.enable) begin
                        r_op1  <= io_bus.op1;
                        r_op2  <= io_bus.op2;
                        r_sign <= io_bus.sign_en;
                    end
                end
                S_PREP: begin
                    r_qsign <= r_sign & (r_op1[WIDTH-1] ^ r_op2[WIDTH-1]);
                    r_rsign <= r_sign & r_op1[WIDTH-1];
                    r_b     <= w_abs2;
                    r_cnt   <= '0;
                    // A skipped divide leaves quotient 0 and the dividend as remainder.
                    if (w_skip) begin
                        r_a <= '0;
                        r_p <= {2'b00, w_abs1};
                    end else begin
                        r_a <= w_abs1;
                        r_p <= '0;
                    end
                end
                S_CALC: begin
                    r_p   <= w_p_step;
                    r_a   <= {r_a[WIDTH-2:0], ~w_p_step[WIDTH+1]};
                    r_cnt <= r_cnt + 6'd1;
                end
                S_FIX: begin
                    r_quo <= w_div0 ? '1 : (r_qsign ? -r_a : r_a);
                    r_rem <= w_div0 ? r_op1 : (r_rsign ? -w_rem_mag : w_rem_mag);
                end
                default: ;
            endcase
        end
    end

    assign io_bus.quo_o = r_quo;
    assign io_bus.rem_o = r_rem;
    assign io_bus.ready = w_ready;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_div_core_radix2.sv
// Directed plus randomized bench for div_core_radix2 against an arithmetic reference model.
// Latency expectations follow DIV_FAST_EN when the bench is built with that macro.
module tb_div_core_radix2;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         total;
    int         bad;

    div_core_radix2_if #(.WIDTH(32)) bus ();

    div_core_radix2 #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .io_bus      (bus.slave),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain SV division, with the two corner cases defined by the block.
    task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output logic [31:0] q, output logic [31:0] r, output int lat);
        int          sa;
        int          sb;
        logic [31:0] abs_a;
        logic [31:0] abs_b;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        abs_a = (s && a[31]) ? 32'(0 - sa) : a;
        abs_b = (s && b[31]) ? 32'(0 - sb) : b;
        lat = 35;
`ifdef DIV_FAST_EN
        if (b == 32'd0 || abs_a < abs_b) lat = 3;
`endif
        if (abs_a == abs_b + 32'd1) lat = lat;
    endtask

    // Drives a request in the current cycle, scrambles inputs while busy and checks
    // latency, output hold during busy, and the final results. Returns in the cycle
    // ready rises so the next call is accepted back-to-back.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic s);
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic [31:0] prev_q;
        logic [31:0] prev_r;
        int          lat;
        int          cycles;
        logic        stable;
        ref_div(a, b, s, exp_q, exp_r, lat);
        bus.enable  = 1'b1;
        bus.op1     = a;
        bus.op2     = b;
        bus.sign_en = s;
        @(posedge clk);
        #1;
        check({tag, "_busy"}, 32'(bus.ready), 32'd0);
        prev_q = bus.quo_o;
        prev_r = bus.rem_o;
        stable = 1'b1;
        cycles = 0;
        while (bus.ready !== 1'b1 && cycles < 40) begin
            bus.enable  = 1'($urandom);
            bus.op1     = $urandom;
            bus.op2     = $urandom;
            bus.sign_en = 1'($urandom);
            @(posedge clk);
            #1;
            cycles++;
            if (bus.ready !== 1'b1 && (bus.quo_o !== prev_q || bus.rem_o !== prev_r))
                stable = 1'b0;
        end
        bus.enable = 1'b0;
        check({tag, "_lat"}, 32'(cycles), 32'(lat - 1));
        check({tag, "_hold"}, 32'(stable), 32'd1);
        check({tag, "_quo"}, bus.quo_o, exp_q);
        check({tag, "_rem"}, bus.rem_o, exp_r);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        bus.enable  = 1'b0;
        bus.sign_en = 1'b0;
        bus.op1     = '0;
        bus.op2     = '0;
        #1;
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_quo", bus.quo_o, 32'd0);
        check("rst_rem", bus.rem_o, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op("u100_7", 32'd100, 32'd7, 1'b0);
        do_op("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        do_op("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        do_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        do_op("u5_0", 32'd5, 32'd0, 1'b0);
        do_op("s_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1);
        do_op("u3_8", 32'd3, 32'd8, 1'b0);
        do_op("s_m3_8", 32'hFFFF_FFFD, 32'd8, 1'b1);
        do_op("umax_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
        do_op("umax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Abort mid-operation at N+10; the previous nonzero result must be cleared.
        bus.enable  = 1'b1;
        bus.op1     = 32'd1000;
        bus.op2     = 32'd10;
        bus.sign_en = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 9; i++) begin
            bus.enable = 1'($urandom);
            bus.op1    = $urandom;
            bus.op2    = $urandom;
            @(posedge clk);
            #1;
        end
        check("abort_busy", 32'(bus.ready), 32'd0);
        rst = 1'b1;
        #1;
        check("abort_ready", 32'(bus.ready), 32'd1);
        check("abort_quo", bus.quo_o, 32'd0);
        check("abort_rem", bus.rem_o, 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        bus.enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_op("u9_3", 32'd9, 32'd3, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: a = $urandom_range(0, 1000);
                3: b = 32'hFFFF_FFFF;
                4: a = 32'h8000_0000;
                5: b = 32'(0 - $urandom_range(1, 100));
                default: ;
            endcase
            do_op("rand", a, b, 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
